// File: rtl/pdm_modulator_pkg.sv
// Shared constants for the PDM transmit path: default widths, the feedback
// full-scale value and the integrator clamp limits.
package pdm_modulator_pkg;

    localparam int BUS_WIDTH_DEF  = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int ACC_WIDTH_DEF  = 20;

    // Feedback magnitude: the bitstream swings between +/- half of the PCM code range.
    function automatic longint pdm_full_scale(input int bus_width);
        return longint'(1) <<< (bus_width - 1);
    endfunction

    function automatic longint acc_max(input int acc_width);
        return (longint'(1) <<< (acc_width - 1)) - 1;
    endfunction

    function automatic longint acc_min(input int acc_width);
        return -(longint'(1) <<< (acc_width - 1));
    endfunction

endpackage

// File: rtl/pdm_modulator_pcm_fifo.sv
// Purpose: small synchronous sample FIFO with flush and occupancy level.
// Latency: a pushed entry becomes the head on the following edge.
// Backpressure: full/empty exported; push when full or pop when empty is ignored.
module pcm_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign push_ok  = push & ~full & ~flush;
    assign pop_ok   = pop & ~empty & ~flush;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop_ok)      level <= level + LW'(1);
            else if (pop_ok && !push_ok) level <= level - LW'(1);
        end
    end

    // Storage needs no reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/pdm_modulator.sv
// Purpose: PCM-to-PDM transmitter (sample FIFO feeding a 2nd-order delta-sigma loop).
// Latency: one PDM bit registered one cycle after each ce_pdm; new sample used from the next ce_pdm.
// Backpressure: pcm_ready_o drops while the FIFO is full; an empty FIFO on ce_pcm sets sticky underrun.
module pdm_modulator
    import pdm_modulator_pkg::*;
#(
    parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          ce_pdm,
    input  logic                          ce_pcm,
    input  logic                          enable,
    input  logic                          mclear,
    input  logic signed [BUS_WIDTH-1:0]   pcm_i,
    input  logic                          pcm_valid_i,
    output logic                          pcm_ready_o,
    output logic                          pdm_data_o,
    output logic                          underrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int SUM_W = ACC_WIDTH + 2;
    localparam logic signed [SUM_W-1:0] FS     = SUM_W'(pdm_full_scale(BUS_WIDTH));
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(acc_max(ACC_WIDTH));
    localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(acc_min(ACC_WIDTH));

    logic signed [BUS_WIDTH-1:0] cur_sample;
    logic        [BUS_WIDTH-1:0] head;
    logic signed [ACC_WIDTH-1:0] i1, i2, i1_nxt, i2_nxt;
    logic signed [SUM_W-1:0]     fb, i1_sum, i2_sum;
    logic                        full, empty, push, pop;

    function automatic logic signed [ACC_WIDTH-1:0] clamp(input logic signed [SUM_W-1:0] v);
        if (v > SAT_HI)      return SAT_HI[ACC_WIDTH-1:0];
        else if (v < SAT_LO) return SAT_LO[ACC_WIDTH-1:0];
        else                 return v[ACC_WIDTH-1:0];
    endfunction

    assign pcm_ready_o = ~full;
    assign push        = pcm_valid_i & ~full & ~mclear;
    assign pop         = ce_pcm & enable & ~mclear & ~empty;

    pcm_fifo #(
        .WIDTH (BUS_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_i),
        .flush    (mclear),
        .push     (push),
        .push_dat (pcm_i),
        .pop      (pop),
        .head_dat (head),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level_o)
    );

    // Intermediate sums are two bits wider than the integrators so clamping sees the true value.
    always_comb begin
        fb     = pdm_data_o ? FS : -FS;
        i1_sum = SUM_W'(i1) + SUM_W'(cur_sample) - fb;
        i1_nxt = clamp(i1_sum);
        i2_sum = SUM_W'(i2) + SUM_W'(i1_nxt) - fb;
        i2_nxt = clamp(i2_sum);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cur_sample <= '0;
            i1         <= '0;
            i2         <= '0;
            pdm_data_o <= 1'b0;
            underrun_o <= 1'b0;
        end else if (mclear) begin
            cur_sample <= '0;
            i1         <= '0;
            i2         <= '0;
            pdm_data_o <= 1'b0;
            underrun_o <= 1'b0;
        end else if (!enable) begin
            cur_sample <= '0;
            i1         <= '0;
            i2         <= '0;
            if (ce_pdm) pdm_data_o <= ~pdm_data_o;
        end else begin
            if (ce_pdm) begin
                i1         <= i1_nxt;
                i2         <= i2_nxt;
                pdm_data_o <= ~i2_nxt[ACC_WIDTH-1];
            end
            if (ce_pcm) begin
                if (empty) underrun_o <= 1'b1;
                else       cur_sample <= head;
            end
        end
    end

endmodule

// File: tb/tb_pdm_modulator.sv
// Randomized and directed bench for pdm_modulator with a queue-based reference model
// and a decoupled monitor that scores every PDM bit against the expected stream.
module tb_pdm_modulator;

    localparam int BW    = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 20;
    localparam int LW    = 3;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b0;
    logic          ce_pdm = 1'b0, ce_pcm = 1'b0, enable = 1'b0, mclear = 1'b0;
    logic [BW-1:0] pcm_i = '0;
    logic          pcm_valid_i = 1'b0;
    logic          pcm_ready_o, pdm_data_o, underrun_o;
    logic [LW-1:0] fifo_level_o;

    always #5 wb_clk_i = ~wb_clk_i;

    pdm_modulator #(.BUS_WIDTH(BW), .FIFO_DEPTH(DEPTH), .ACC_WIDTH(AW)) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .ce_pdm       (ce_pdm),
        .ce_pcm       (ce_pcm),
        .enable       (enable),
        .mclear       (mclear),
        .pcm_i        (pcm_i),
        .pcm_valid_i  (pcm_valid_i),
        .pcm_ready_o  (pcm_ready_o),
        .pdm_data_o   (pdm_data_o),
        .underrun_o   (underrun_o),
        .fifo_level_o (fifo_level_o)
    );

    // Reference model state: sample queue, held sample, integrators, last bit, sticky flag.
    longint mq[$];
    longint m_cur, m_i1, m_i2;
    bit     m_bit, m_under;
    bit     exp_q[$];

    int n_tests = 0, n_fail = 0;
    int ones_cnt = 0, bits_cnt = 0, max_run = 0, run_len = 0, last_bit = -1;
    logic mon_pend = 1'b0;

    localparam longint FS = longint'(1) <<< (BW - 1);

    function automatic longint msat(input longint v);
        longint hi, lo;
        hi = (longint'(1) <<< (AW - 1)) - 1;
        lo = -(longint'(1) <<< (AW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_cur = 0; m_i1 = 0; m_i2 = 0; m_bit = 1'b0; m_under = 1'b0;
    endtask

    // One clock cycle of stimulus; the model advances alongside and posts any expected bit.
    task automatic cyc(input bit v, input logic [BW-1:0] d, input bit pcm, input bit pdm,
                       input bit en, input bit clr);
        bit     acc;
        longint fb;
        pcm_valid_i = v; pcm_i = d; ce_pcm = pcm; ce_pdm = pdm; enable = en; mclear = clr;
        if (clr) begin
            model_clear();
        end else begin
            acc = v && (mq.size() < DEPTH);
            if (pdm) begin
                if (en) begin
                    fb    = m_bit ? FS : -FS;
                    m_i1  = msat(m_i1 + m_cur - fb);
                    m_i2  = msat(m_i2 + m_i1 - fb);
                    m_bit = (m_i2 >= 0);
                end else begin
                    m_bit = ~m_bit;
                end
                exp_q.push_back(m_bit);
            end
            if (pcm && en) begin
                if (mq.size() > 0) m_cur = mq.pop_front();
                else               m_under = 1'b1;
            end
            if (acc) mq.push_back(longint'($signed(d)));
            if (!en) begin
                m_cur = 0; m_i1 = 0; m_i2 = 0;
            end
        end
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        #1;
        chk("level", int'(fifo_level_o), mq.size());
        chk("ready", int'(pcm_ready_o), int'(mq.size() < DEPTH));
        chk("underrun", int'(underrun_o), int'(m_under));
    endtask

    task automatic reset_counts();
        ones_cnt = 0; bits_cnt = 0; max_run = 0; run_len = 0; last_bit = -1;
    endtask

    task automatic run_dc(input logic [BW-1:0] s, input int n, input int lo, input int hi,
                          input bit check_runs);
        cyc(0, '0, 0, 0, 0, 1);
        cyc(1, s, 0, 0, 0, 0);
        cyc(0, '0, 1, 0, 1, 0);
        reset_counts();
        for (int i = 0; i < n; i++) begin
            cyc(0, '0, 0, 1, 1, 0);
            if ($urandom_range(0, 2) == 0) cyc(0, '0, 0, 0, 1, 0);
        end
        chk("dc_bits", bits_cnt, n);
        chk_range("dc_ones", ones_cnt, lo, hi);
        if (check_runs) chk_range("dc_max_run", max_run, 1, 2);
    endtask

    // Monitor: every ce_pdm accepted on an edge yields one bit, scored at the following falling edge.
    always @(posedge wb_clk_i) mon_pend <= ce_pdm & ~mclear & wb_rst_i;

    always @(negedge wb_clk_i) begin
        if (mon_pend && wb_rst_i) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pdm_extra: got bit %0b with no expected bit queued", pdm_data_o);
            end else if (pdm_data_o !== exp_q[0]) begin
                n_fail++;
                $display("FAIL pdm_bit: got %0b, expected %0b at %0t", pdm_data_o, exp_q[0], $time);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
            bits_cnt++;
            ones_cnt += int'(pdm_data_o);
            if (int'(pdm_data_o) == last_bit) run_len++;
            else begin
                run_len  = 1;
                last_bit = int'(pdm_data_o);
            end
            if (run_len > max_run) max_run = run_len;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        model_clear();
        #12;
        chk("rst_pdm", int'(pdm_data_o), 0);
        chk("rst_level", int'(fifo_level_o), 0);
        chk("rst_ready", int'(pcm_ready_o), 1);
        chk("rst_underrun", int'(underrun_o), 0);
        @(negedge wb_clk_i);
        #1 wb_rst_i = 1'b1;
        cyc(0, '0, 0, 0, 0, 0);
        chk("post_rst_pdm", int'(pdm_data_o), 0);

        // FIFO fill while disabled, then a single pop frees one slot.
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            bit will_acc;
            will_acc = (idx < 5) && (mq.size() < DEPTH);
            cyc(idx < 5, 16'(idx + 1), 0, 0, 0, 0);
            if (will_acc) idx++;
        end
        chk("full_level", int'(fifo_level_o), 4);
        chk("full_ready", int'(pcm_ready_o), 0);
        cyc(1, 16'h0005, 1, 0, 1, 0);
        chk("pop_level", int'(fifo_level_o), 3);
        chk("pop_ready", int'(pcm_ready_o), 1);
        cyc(1, 16'h0005, 0, 0, 0, 0);
        chk("refill_level", int'(fifo_level_o), 4);

        run_dc(16'h0000, 256, 126, 130, 1'b1);
        run_dc(16'h4000, 1024, 764, 772, 1'b0);
        run_dc(16'hC000, 1024, 252, 260, 1'b0);
        run_dc(16'h7FFF, 1024, 1016, 1024, 1'b0);

        // Underrun holds the previous sample; mclear then wipes everything.
        cyc(0, '0, 0, 0, 0, 1);
        cyc(1, 16'h4000, 0, 0, 0, 0);
        cyc(0, '0, 1, 0, 1, 0);
        cyc(0, '0, 1, 0, 1, 0);
        chk("underrun_set", int'(underrun_o), 1);
        reset_counts();
        for (int i = 0; i < 64; i++) cyc(0, '0, 0, 1, 1, 0);
        chk_range("held_ones", ones_cnt, 44, 52);
        cyc(1, 16'h1234, 0, 0, 1, 0);
        cyc(1, 16'h5678, 0, 0, 1, 0);
        chk("pre_clear_level", int'(fifo_level_o), 2);
        cyc(1, 16'h1111, 0, 1, 1, 1);
        chk("clear_underrun", int'(underrun_o), 0);
        chk("clear_level", int'(fifo_level_o), 0);
        chk("clear_pdm", int'(pdm_data_o), 0);

        // Same-cycle push and pop on an empty FIFO: pop underruns, push lands.
        cyc(1, 16'h2222, 1, 0, 1, 0);
        chk("push_pop_empty_under", int'(underrun_o), 1);
        chk("push_pop_empty_level", int'(fifo_level_o), 1);

        // Random traffic.
        begin
            bit en;
            en = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 199) == 0) en = ~en;
                cyc($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 11) == 0,
                    $urandom_range(0, 1) == 1, en, $urandom_range(0, 299) == 0);
            end
        end

        // Asynchronous reset in the middle of a cycle.
        cyc(0, '0, 0, 0, 0, 1);
        cyc(1, 16'h7FFF, 0, 0, 0, 0);
        cyc(0, '0, 1, 0, 1, 0);
        cyc(1, 16'h7FFF, 0, 1, 1, 0);
        cyc(1, 16'h7FFF, 0, 1, 1, 0);
        cyc(1, 16'h7FFF, 0, 1, 1, 0);
        #2;
        ce_pdm = 1'b0; ce_pcm = 1'b0; pcm_valid_i = 1'b0;
        wb_rst_i = 1'b0;
        #1;
        chk("async_rst_pdm", int'(pdm_data_o), 0);
        chk("async_rst_level", int'(fifo_level_o), 0);
        chk("async_rst_ready", int'(pcm_ready_o), 1);
        model_clear();
        exp_q.delete();
        @(negedge wb_clk_i);
        #1 wb_rst_i = 1'b1;
        cyc(0, '0, 0, 0, 0, 0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pdm_modulator.md
Name: pdm_modulator

Overview:
- Transmit-side counterpart of the CIC/PDM receive path: turns 16-bit signed PCM samples into a 1-bit PDM stream paced by ce_pdm.
- Provides a loopback/test source for the microphone input (drives pdm_data_i) and can also drive an external ultrasonic transducer.
- A small sample FIFO is popped on ce_pcm, and a 2nd-order delta-sigma loop produces one bit per ce_pdm.

Parameters:
- BUS_WIDTH, 16, PCM sample width (signed two's complement).
- FIFO_DEPTH, 4, sample FIFO entries (power of 2, ≥2).
- ACC_WIDTH, 20, integrator width (signed, > BUS_WIDTH+2).

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  asynchronous, active-low reset.
- ce_pdm  in  1  one-cycle strobe; one PDM bit per strobe.
- ce_pcm  in  1  one-cycle strobe; loads the next sample.
- enable  in  1  modulator run (level).
- mclear  in  1  synchronous flush/clear (level, one cycle is sufficient).
- pcm_i  in  BUS_WIDTH  signed sample.
- pcm_valid_i  in  1  sample offered.
- pcm_ready_o  out  1  FIFO not full.
- pdm_data_o  out  1  registered PDM bit.
- underrun_o  out  1  sticky: ce_pcm seen with FIFO empty while enabled.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  entries stored.

Behaviour:
- Reset (wb_rst_i=0, async): FIFO empty, fifo_level_o=0, pcm_ready_o=1, pdm_data_o=0, underrun_o=0, cur_sample=0, i1=i2=0.
- Push: a sample is accepted on a clock edge with pcm_valid_i & pcm_ready_o. pcm_ready_o = !full (combinational from the level). Valid while full is not accepted; the source must hold it.
- Pop: on ce_pcm & enable & !mclear:
  - FIFO non-empty: cur_sample <= head.
  - FIFO empty: cur_sample holds its value and underrun_o <= 1.
- Push and pop in the same cycle both occur and the level is unchanged. A push into an empty FIFO is not visible to a pop in the same cycle; that pop underruns.
- Modulator step on ce_pdm & enable & !mclear:
  - x = sext(cur_sample).
  - fb = pdm_data_o ? +2^(BUS_WIDTH-1) : -2^(BUS_WIDTH-1).
  - i1' = sat(i1 + x - fb).
  - i2' = sat(i2 + i1' - fb).
  - pdm_data_o <= (i2' >= 0).
  - sat clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; integrators never wrap.
- Long-run ones density = (x/2^(BUS_WIDTH-1) + 1)/2.
- ce_pcm and ce_pdm in the same cycle: the modulator uses the pre-update cur_sample, so the new sample takes effect from the next ce_pdm.
- enable=0:
  - i1, i2 and cur_sample are forced to 0.
  - pdm_data_o toggles on each ce_pdm (idle pattern, zero mean).
  - The FIFO still accepts pushes and no pops occur.
- mclear=1 (sync, priority over everything except reset):
  - FIFO flushed (level 0), underrun_o=0, i1=i2=0, cur_sample=0, pdm_data_o=0.
  - A push in the same cycle is dropped.
- Reset mid-stream: all state is cleared immediately, with no wait for a clock edge.
- Latency: the first bit reflecting a new sample appears on the ce_pdm strictly after the ce_pcm that loaded it, registered one cycle after that strobe.

Decomposition:
- Shared package: BUS_WIDTH default, PDM full-scale constant 2^(BUS_WIDTH-1), integrator clamp limits as functions of ACC_WIDTH.
- One sub-module, pcm_fifo: synchronous FIFO with push, pop, flush, full, empty and level; async active-low reset.
- Modulator arithmetic and control stay in pdm_modulator.

Test Plan:
- Reset: assert wb_rst_i=0 mid-cycle → outputs clear immediately. After release: pcm_ready_o=1, fifo_level_o=0, pdm_data_o=0, underrun_o=0.
- FIFO full: enable=0, hold valid with 5 samples 0x0001..0x0005 → 4 accepted, fifo_level_o=4, pcm_ready_o=0. Then one ce_pcm with enable=1 → level 3, ready=1, and 0x0005 is accepted next edge.
- DC zero: push 0x0000, enable, ce_pcm, then 256 ce_pdm → ones=128±2 and no runs longer than 2.
- DC ±half scale over 1024 ce_pdm:
  - 0x4000 → ones=768±4.
  - 0xC000 → ones=256±4.
- Full scale: 0x7FFF over 1024 ce_pdm → ones ≥1016, integrators saturate without wrap, and the stream never inverts.
- Underrun/mclear: enable with an empty FIFO, pulse ce_pcm → underrun_o=1 and cur_sample held. Push 2 samples, pulse mclear → underrun_o=0, level 0, pdm_data_o=0.
